// File: rtl/ifid_pipe_reg_if.sv
// IF/ID stage bus: fetch-side valid/ready beat in, decode-side head out.
interface ifid_pipe_reg_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] instr_in;
    logic [ADDR_W-1:0] pc_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] instr_d;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc4_d;
    logic [ADDR_W-1:0] pc8_d;
    logic              adel_d;

    modport master (
        output in_valid, instr_in, pc_in, out_ready,
        input  in_ready, out_valid, instr_d, pc_d, pc4_d, pc8_d, adel_d
    );

    modport slave (
        input  in_valid, instr_in, pc_in, out_ready,
        output in_ready, out_valid, instr_d, pc_d, pc4_d, pc8_d, adel_d
    );
endinterface

// File: rtl/ifid_pipe_reg.sv
// IF/ID pipeline register with optional 2-entry skid buffer and
// interrupt/eret/flush redirects that turn held entries into bubbles.
module ifid_pipe_reg #(
    parameter int                 DATA_W   = 32,
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = 32'h0000_3000,
    parameter logic [ADDR_W-1:0]  EXC_VEC  = 32'h0000_4180,
    parameter logic [DATA_W-1:0]  NOP      = 32'h0000_0000,
    parameter int                 SKID     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              intreq,
    input  logic              eret,
    input  logic [ADDR_W-1:0] epc,
    input  logic              flush,
    ifid_pipe_reg_if.slave    bus
);
    typedef enum logic [1:0] {EMPTY, HEAD, FULL} state_t;

    state_t            state;
    logic [DATA_W-1:0] head_instr, skid_instr;
    logic [ADDR_W-1:0] head_pc, skid_pc;
    logic              head_adel, skid_adel;
    logic              rdy_q;
    logic              redirect, xin, xout, in_adel;

    assign redirect = intreq || eret;

    // With the skid buffer, in_ready comes from a register so a decode stall
    // never reaches fetch combinationally; redirects still gate it.
    assign bus.in_ready  = (SKID != 0) ? (rdy_q && !redirect)
                                       : ((bus.out_ready || state == EMPTY) && !redirect);
    assign bus.out_valid = (state != EMPTY);
    assign bus.instr_d   = head_instr;
    assign bus.pc_d      = head_pc;
    assign bus.pc4_d     = head_pc + ADDR_W'(4);
    assign bus.pc8_d     = head_pc + ADDR_W'(8);
    assign bus.adel_d    = head_adel;

    assign xin     = bus.in_valid && bus.in_ready;
    assign xout    = bus.out_valid && bus.out_ready;
    assign in_adel = (bus.pc_in[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= EMPTY;
            head_instr <= NOP;
            head_pc    <= RESET_PC;
            head_adel  <= 1'b0;
            skid_instr <= '0;
            skid_pc    <= '0;
            skid_adel  <= 1'b0;
            rdy_q      <= 1'b1;
        end else if (intreq || eret || flush) begin
            state      <= EMPTY;
            head_instr <= NOP;
            head_adel  <= 1'b0;
            rdy_q      <= 1'b1;
            if (intreq)
                head_pc <= EXC_VEC;
            else if (eret)
                head_pc <= epc;
        end else begin
            case (state)
                EMPTY: begin
                    if (xin) begin
                        head_instr <= bus.instr_in;
                        head_pc    <= bus.pc_in;
                        head_adel  <= in_adel;
                        state      <= HEAD;
                    end
                end
                HEAD: begin
                    // Without a skid buffer, xin in HEAD implies xout.
                    if (xin && xout) begin
                        head_instr <= bus.instr_in;
                        head_pc    <= bus.pc_in;
                        head_adel  <= in_adel;
                    end else if (xin) begin
                        skid_instr <= bus.instr_in;
                        skid_pc    <= bus.pc_in;
                        skid_adel  <= in_adel;
                        state      <= FULL;
                        rdy_q      <= 1'b0;
                    end else if (xout) begin
                        head_instr <= NOP;
                        head_adel  <= 1'b0;
                        state      <= EMPTY;
                    end
                end
                FULL: begin
                    if (xout) begin
                        head_instr <= skid_instr;
                        head_pc    <= skid_pc;
                        head_adel  <= skid_adel;
                        state      <= HEAD;
                        rdy_q      <= 1'b1;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_ifid_pipe_reg.sv
// Bench for ifid_pipe_reg: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ifid_pipe_reg;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC  = 32'h0000_4180;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset, intreq, eret, flush;
    logic [31:0] epc;
    int          compared   = 0;
    int          mismatched = 0;

    beat_t       mq[$];
    logic [31:0] shown_pc = RESET_PC;
    bit          mdl_on   = 1'b0;

    ifid_pipe_reg_if #(.DATA_W(32), .ADDR_W(32)) bus();

    ifid_pipe_reg #(
        .DATA_W(32), .ADDR_W(32), .RESET_PC(RESET_PC),
        .EXC_VEC(EXC_VEC), .NOP(NOP), .SKID(1)
    ) dut (
        .clk(clk), .reset(reset), .intreq(intreq), .eret(eret),
        .epc(epc), .flush(flush), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit exp_rdy();
        return !intreq && !eret && (mq.size() < 2);
    endfunction

    // Reference model: a FIFO of at most two beats plus the last PC shown.
    always @(posedge clk) begin : mdl_upd
        bit    r, v;
        beat_t b;
        r = exp_rdy();
        v = (mq.size() > 0);
        if (reset) begin
            mq.delete();
            shown_pc = RESET_PC;
            mdl_on   = 1'b1;
        end else if (mdl_on) begin
            if (intreq) begin
                mq.delete();
                shown_pc = EXC_VEC;
            end else if (eret) begin
                mq.delete();
                shown_pc = epc;
            end else if (flush) begin
                mq.delete();
            end else begin
                if (v && bus.out_ready)
                    void'(mq.pop_front());
                if (bus.in_valid && r) begin
                    b.instr = bus.instr_in;
                    b.pc    = bus.pc_in;
                    mq.push_back(b);
                end
                if (mq.size() > 0)
                    shown_pc = mq[0].pc;
            end
        end
    end

    always @(negedge clk) begin : cmp
        bit v;
        if (mdl_on) begin
            v = (mq.size() > 0);
            chk("out_valid", 32'(bus.out_valid), 32'(v));
            chk("instr_d", bus.instr_d, v ? mq[0].instr : NOP);
            chk("pc_d", bus.pc_d, shown_pc);
            chk("pc4_d", bus.pc4_d, shown_pc + 32'd4);
            chk("pc8_d", bus.pc8_d, shown_pc + 32'd8);
            chk("adel_d", 32'(bus.adel_d), 32'(v && (mq[0].pc[1:0] != 2'b00)));
            if (!reset)
                chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        intreq = 0; eret = 0; flush = 0; epc = '0;
        bus.in_valid = 0; bus.instr_in = '0; bus.pc_in = '0; bus.out_ready = 0;
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] instr);
        bus.in_valid = 1; bus.pc_in = pc; bus.instr_in = instr;
    endtask

    initial begin
        idle();
        reset = 1;
        tick(); tick();
        reset = 0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_pc_d", bus.pc_d, 32'h0000_3000);
        chk("rst_pc4_d", bus.pc4_d, 32'h0000_3004);
        chk("rst_pc8_d", bus.pc8_d, 32'h0000_3008);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Streaming at one beat per cycle.
        bus.out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            send(32'h3000 + 32'(4 * i), 32'hA000_0000 + 32'(i));
            tick();
            chk("stream_instr", bus.instr_d, 32'hA000_0000 + 32'(i));
            chk("stream_pc8", bus.pc8_d, 32'h3008 + 32'(4 * i));
        end
        bus.in_valid = 0;
        tick();
        chk("stream_drain", 32'(bus.out_valid), 32'd0);

        // Stall: A held, B goes to skid, C is held off.
        bus.out_ready = 0;
        send(32'h3000, 32'hAAAA_0001); tick();
        send(32'h3004, 32'hBBBB_0002); tick();
        chk("full_head", bus.instr_d, 32'hAAAA_0001);
        send(32'h3008, 32'hCCCC_0003); #1;
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        chk("full_hold", bus.instr_d, 32'hAAAA_0001);
        bus.out_ready = 1; tick();
        chk("drain_b", bus.instr_d, 32'hBBBB_0002);
        tick();
        chk("drain_c", bus.instr_d, 32'hCCCC_0003);
        chk("drain_c_pc", bus.pc_d, 32'h0000_3008);
        bus.in_valid = 0; tick();

        // Interrupt while full.
        bus.out_ready = 0;
        send(32'h3010, 32'h1234_0001); tick();
        send(32'h3014, 32'h1234_0002); tick();
        bus.in_valid = 0;
        intreq = 1; #1;
        chk("int_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        intreq = 0;
        chk("int_out_valid", 32'(bus.out_valid), 32'd0);
        chk("int_instr", bus.instr_d, 32'h0000_0000);
        chk("int_pc", bus.pc_d, 32'h0000_4180);
        chk("int_pc8", bus.pc8_d, 32'h0000_4188);
        #1;
        chk("int_empty_rdy", 32'(bus.in_ready), 32'd1);

        // eret beats flush; PC wrap; misaligned PC.
        eret = 1; flush = 1; epc = 32'h0000_3040;
        tick();
        eret = 0; flush = 0;
        chk("eret_pc", bus.pc_d, 32'h0000_3040);
        chk("eret_pc4", bus.pc4_d, 32'h0000_3044);
        bus.out_ready = 1;
        send(32'hFFFF_FFFC, 32'h1111_1111); tick();
        chk("wrap_pc8", bus.pc8_d, 32'h0000_0004);
        chk("wrap_adel", 32'(bus.adel_d), 32'd0);
        send(32'h0000_3002, 32'h2222_2222); tick();
        chk("mis_adel", 32'(bus.adel_d), 32'd1);
        chk("mis_pc", bus.pc_d, 32'h0000_3002);
        bus.in_valid = 0; tick();
        chk("mis_drain_adel", 32'(bus.adel_d), 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            reset  = ($urandom_range(0, 99) == 0);
            intreq = ($urandom_range(0, 49) == 0);
            eret   = ($urandom_range(0, 49) == 0);
            flush  = ($urandom_range(0, 32) == 0);
            epc    = $urandom() & ($urandom_range(0, 7) == 0 ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            bus.out_ready = ($urandom_range(0, 9) < 6);
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.instr_in  = $urandom();
            case ($urandom_range(0, 9))
                0:       bus.pc_in = $urandom();
                1:       bus.pc_in = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
                default: bus.pc_in = $urandom() & 32'hFFFF_FFFC;
            endcase
            tick();
        end
        idle();
        reset = 0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
